addsub_16bit_seq: RTL and testbench

- Multi-cycle, chunk-serial 16-bit adder/subtractor with valid/ready handshakes on input and output.
- Sequential counterpart of the combinational adder_16bit; the arithmetic contract is unchanged: sum = a + b + carry_in, overflow = unsigned carry out.
- Adds a subtract mode and processes CHUNK_BITS bits per cycle through one shared small adder, for area-constrained datapaths.
- Sits between an operand producer and a result consumer in the Lab datapath.

---
 rtl/addsub_pkg.sv | 6 +
 rtl/chunk_adder.sv | 19 +
 rtl/addsub_16bit_seq.sv | 92 +++++++++
 tb/tb_addsub_16bit_seq.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// addsub_pkg: shared FSM state type and default widths for addsub_16bit_seq.
package addsub_pkg;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   localparam int DEF_NUM_BITS   = 16;
   localparam int DEF_CHUNK_BITS = 4;
endpackage

// File: rtl/chunk_adder.sv
// chunk_adder: combinational W-bit adder; ADDSUB_SIGNED_OVF_EN adds the carry into the MSB.
module chunk_adder #(
   parameter int W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] s,
   output logic         cout
`ifdef ADDSUB_SIGNED_OVF_EN
   , output logic       c_msb
`endif
);
   assign {cout, s} = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
`ifdef ADDSUB_SIGNED_OVF_EN
   // the sum bit is a^b^carry, so the carry into the MSB falls out of it
   assign c_msb = s[W-1] ^ a[W-1] ^ b[W-1];
`endif
endmodule

// File: rtl/addsub_16bit_seq.sv
// addsub_16bit_seq: chunk-serial adder/subtractor with valid/ready handshakes.
// Defining ADDSUB_SIGNED_OVF_EN adds the signed_ovf output.
module addsub_16bit_seq
   import addsub_pkg::*;
#(
   parameter int NUM_BITS   = DEF_NUM_BITS,
   parameter int CHUNK_BITS = DEF_CHUNK_BITS
) (
   input  logic                clk,
   input  logic                n_rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [NUM_BITS-1:0] a,
   input  logic [NUM_BITS-1:0] b,
   input  logic                carry_in,
   input  logic                sub,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [NUM_BITS-1:0] sum,
   output logic                overflow
`ifdef ADDSUB_SIGNED_OVF_EN
   , output logic              signed_ovf
`endif
);
   localparam int NUM_CHUNKS = NUM_BITS / CHUNK_BITS;
   localparam int CW = $clog2(NUM_CHUNKS + 1);
   state_t state, next;
   logic [NUM_BITS-1:0] op_a, op_b;
   logic [CHUNK_BITS-1:0] cs;
   logic [CW-1:0] cnt;
   logic carry, sub_r, cout, last;
`ifdef ADDSUB_SIGNED_OVF_EN
   logic c_msb;
`endif
   assign last = cnt == CW'(NUM_CHUNKS - 1);
   chunk_adder #(.W(CHUNK_BITS)) u_add (
      .a(op_a[CHUNK_BITS-1:0]),
      .b(op_b[CHUNK_BITS-1:0]),
      .cin(carry),
      .s(cs),
      .cout(cout)
`ifdef ADDSUB_SIGNED_OVF_EN
      , .c_msb(c_msb)
`endif
   );
   always_ff @(posedge clk or negedge n_rst)
      if (!n_rst) state <= IDLE;
      else state <= next;
   always_comb begin
      next = state;
      if (state == IDLE && in_valid) next = BUSY;
      else if (state == BUSY && last) next = DONE;
      else if (state == DONE && out_ready) next = IDLE;
   end
   always_comb begin
      in_ready  = state == IDLE;
      out_valid = state == DONE;
   end
   // subtraction is a + ~b + !borrow, so the adder never needs to know the mode
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         op_a     <= '0;
         op_b     <= '0;
         carry    <= 1'b0;
         sub_r    <= 1'b0;
         cnt      <= '0;
         sum      <= '0;
         overflow <= 1'b0;
`ifdef ADDSUB_SIGNED_OVF_EN
         signed_ovf <= 1'b0;
`endif
      end else if (state == IDLE && in_valid) begin
         op_a  <= a;
         op_b  <= sub ? ~b : b;
         carry <= carry_in ^ sub;
         sub_r <= sub;
         cnt   <= '0;
      end else if (state == BUSY) begin
         op_a  <= op_a >> CHUNK_BITS;
         op_b  <= op_b >> CHUNK_BITS;
         carry <= cout;
         sum   <= {cs, sum[NUM_BITS-1:CHUNK_BITS]};
         cnt   <= cnt + CW'(1);
         if (last) begin
            overflow <= cout ^ sub_r;
`ifdef ADDSUB_SIGNED_OVF_EN
            signed_ovf <= c_msb ^ cout;
`endif
         end
      end
   end
endmodule

// File: tb/tb_addsub_16bit_seq.sv
// tb_addsub_16bit_seq: directed scoreboard bench for addsub_16bit_seq.
module tb_addsub_16bit_seq;
   typedef struct packed {
      logic [15:0] s;
      logic        o;
      logic        v;
   } exp_t;
   logic clk = 1'b0, n_rst = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic carry_in = 1'b0, sub = 1'b0;
   logic [15:0] a = '0, b = '0;
   logic in_ready, out_valid, overflow;
   logic [15:0] sum;
`ifdef ADDSUB_SIGNED_OVF_EN
   logic signed_ovf;
`endif
   exp_t q[$];
   int n_cmp = 0, n_err = 0;
   addsub_16bit_seq dut (
      .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .carry_in(carry_in), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .overflow(overflow)
`ifdef ADDSUB_SIGNED_OVF_EN
      , .signed_ovf(signed_ovf)
`endif
   );
   always #5 clk = ~clk;
   function automatic exp_t model(input logic [15:0] x, y, input logic c, s);
      logic [16:0] r;
      exp_t e;
      r = s ? {1'b0, x} - {1'b0, y} - 17'(c) : {1'b0, x} + {1'b0, y} + 17'(c);
      e.s = r[15:0];
      e.o = r[16];
      e.v = (s ? x[15] != y[15] : x[15] == y[15]) && r[15] != x[15];
      return e;
   endfunction
   task automatic chk(input string tag, input logic [16:0] obs, exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic send(input logic [15:0] x, y, input logic c, s);
      int n = 0;
      @(negedge clk);
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("in_ready_wait", 17'(in_ready), 17'd1);
      a = x;
      b = y;
      carry_in = c;
      sub = s;
      in_valid = 1'b1;
      q.push_back(model(x, y, c, s));
      @(negedge clk);
      in_valid = 1'b0;
      chk("busy_not_ready", 17'(in_ready), 17'd0);
   endtask
   task automatic recv(input int stall);
      int n = 0;
      exp_t e;
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("latency", 17'(n), 17'd4);
      chk("queue_depth", 17'(q.size()), 17'd1);
      e = q.size() != 0 ? q.pop_front() : '0;
      if (stall > 0) begin
         out_ready = 1'b0;
         a = 16'h1234;
         b = 16'h4321;
         in_valid = 1'b1;
         for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("hold_valid", 17'(out_valid), 17'd1);
            chk("hold_sum", 17'(sum), 17'(e.s));
            chk("hold_ovf", 17'(overflow), 17'(e.o));
            chk("hold_ready", 17'(in_ready), 17'd0);
         end
         in_valid = 1'b0;
      end
      chk("sum", 17'(sum), 17'(e.s));
      chk("overflow", 17'(overflow), 17'(e.o));
`ifdef ADDSUB_SIGNED_OVF_EN
      chk("signed_ovf", 17'(signed_ovf), 17'(e.v));
`endif
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("valid_drop", 17'(out_valid), 17'd0);
      chk("idle_ready", 17'(in_ready), 17'd1);
      chk("sum_retained", 17'(sum), 17'(e.s));
   endtask
   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
   initial begin
      a = 16'hFFFF;
      b = 16'h0001;
      in_valid = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", 17'(in_ready), 17'd1);
      chk("rst_out_valid", 17'(out_valid), 17'd0);
      chk("rst_sum", 17'(sum), 17'd0);
      chk("rst_ovf", 17'(overflow), 17'd0);
      in_valid = 1'b0;
      n_rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("post_rst_idle", 17'(in_ready), 17'd1);
      chk("post_rst_no_out", 17'(out_valid), 17'd0);
      send(16'h0000, 16'h0000, 1'b0, 1'b0); recv(0);
      send(16'hFFFA, 16'h0001, 1'b0, 1'b0); recv(0);
      send(16'hAAFF, 16'hFFAA, 1'b0, 1'b0); recv(0);
      send(16'hFFFF, 16'h0000, 1'b1, 1'b0); recv(0);
      send(16'h0002, 16'h0001, 1'b0, 1'b1); recv(0);
      send(16'h0001, 16'h0002, 1'b0, 1'b1); recv(0);
      send(16'h0005, 16'h0003, 1'b1, 1'b1); recv(0);
      send(16'h7FFF, 16'h0001, 1'b0, 1'b0); recv(0);
      send(16'h8000, 16'h0001, 1'b0, 1'b1); recv(0);
      send(16'h0001, 16'h0002, 1'b0, 1'b0); recv(5);
      send(16'hAAFF, 16'hFFAA, 1'b0, 1'b0);
      void'(q.pop_back());
      @(negedge clk);
      n_rst = 1'b0;
      #1;
      chk("abort_in_ready", 17'(in_ready), 17'd1);
      chk("abort_out_valid", 17'(out_valid), 17'd0);
      chk("abort_sum", 17'(sum), 17'd0);
      chk("abort_ovf", 17'(overflow), 17'd0);
      @(negedge clk);
      n_rst = 1'b1;
      send(16'h0002, 16'h0001, 1'b0, 1'b0); recv(0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
